// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU; result_o = {remainder (HI), quotient (LO)}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration through a one-cycle DIV_ZERO state.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        annul_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE, DIV_ZERO, ON, END} state_t;
`else
    typedef enum logic [1:0] {IDLE, ON, END} state_t;
`endif

    state_t          state, state_d;
    logic [DW-1:0]   dvd, dvd_d;
    logic [DW-1:0]   dsr, dsr_d;
    logic [DW-1:0]   rem, rem_d;
    logic [DW-1:0]   quo, quo_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            neg_rem, neg_rem_d;
    logic            neg_quo, neg_quo_d;
    logic [2*DW-1:0] result_d;
    logic            ready_d;

    logic [DW:0]     trial;
    logic [DW-1:0]   rem_step;
    logic [DW-1:0]   quo_step;
    logic            op1_neg;
    logic            op2_neg;

    function automatic logic [DW-1:0] negate(input logic [DW-1:0] v);
        return (~v) + DW'(1);
    endfunction

    assign op1_neg = signed_i & opdata1_i[DW-1];
    assign op2_neg = signed_i & opdata2_i[DW-1];
    assign stall_o = start_i & ~ready_o & ~annul_i;

    // Restoring step: a borrow out of the 33-bit trial means the divisor did not fit.
    always_comb begin
        trial    = {rem, dvd[DW-1]} - {1'b0, dsr};
        rem_step = trial[DW] ? {rem[DW-2:0], dvd[DW-1]} : trial[DW-1:0];
        quo_step = {quo[DW-2:0], ~trial[DW]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state;
        dvd_d     = dvd;
        dsr_d     = dsr;
        rem_d     = rem;
        quo_d     = quo;
        cnt_d     = cnt;
        neg_rem_d = neg_rem;
        neg_quo_d = neg_quo;
        result_d  = result_o;
        ready_d   = 1'b0;

        if (annul_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dvd_d     = op1_neg ? negate(opdata1_i) : opdata1_i;
                        dsr_d     = op2_neg ? negate(opdata2_i) : opdata2_i;
                        neg_rem_d = op1_neg;
                        neg_quo_d = op1_neg ^ op2_neg;
                        rem_d     = '0;
                        quo_d     = '0;
                        cnt_d     = '0;
`ifdef DIV_ZERO_FAST_EN
                        state_d   = (opdata2_i == '0) ? DIV_ZERO : ON;
`else
                        state_d   = ON;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DIV_ZERO: begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = END;
                end
`endif
                ON: begin
                    dvd_d = {dvd[DW-2:0], 1'b0};
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        state_d  = END;
                        ready_d  = 1'b1;
                        result_d = {neg_rem ? negate(rem_step) : rem_step,
                                    neg_quo ? negate(quo_step) : quo_step};
                    end
                end
                END: begin
                    if (start_i) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            neg_rem  <= 1'b0;
            neg_quo  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_d;
            dvd      <= dvd_d;
            dsr      <= dsr_d;
            rem      <= rem_d;
            quo      <= quo_d;
            cnt      <= cnt_d;
            neg_rem  <= neg_rem_d;
            neg_quo  <= neg_quo_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor pops them on each ready_o rise.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .annul_i   (annul_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    typedef struct {
        logic [63:0] res;
        int          start_cyc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics (truncating division, remainder takes dividend sign).
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'd0;
`else
            if (sgn && a[31]) return {a, 32'h0000_0001};
            return {a, 32'hFFFF_FFFF};
`endif
        end
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Clock edges from the sampling edge to the edge after which ready_o is high.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 1;
`endif
        return 32;
    endfunction

    // Monitor: compare result and latency on each rising ready_o.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ready_o && !prev) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result 0x%h, expected no result", result_o);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, " result"}, result_o, e.res);
                    chk({e.name, " latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
                end
            end
            prev = ready_o;
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int hold, input string name);
        logic [63:0] exp;
        int          n;
        exp_t        e;
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = sgn;
        start_i   = 1'b1;
        exp       = model(a, b, sgn);
        e.res       = exp;
        e.start_cyc = cyc + 1;
        e.lat       = exp_lat(b);
        e.name      = name;
        sbq.push_back(e);
        @(negedge clk);
        chk({name, " stall_busy"}, 64'(stall_o), 64'd1);
        n = 0;
        while (!ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got ready_o=0 after %0d cycles, expected 1", name, n);
            start_i = 1'b0;
            @(negedge clk);
            return;
        end
        chk({name, " stall_done"}, 64'(stall_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, " hold_ready"}, 64'(ready_o), 64'd1);
            chk({name, " hold_result"}, result_o, exp);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk({name, " release_ready"}, 64'(ready_o), 64'd0);
        chk({name, " release_result"}, result_o, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        int          kind;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_7_m2");
        run_div(32'h1234_5678, 32'd0, 1'b0, 0, "divu_by_zero");
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0, "div_neg_by_zero");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_overflow");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "divu_big");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 5, "divu_hold");

        // Annul mid-division; no result may appear, then a fresh division runs from IDLE.
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        signed_i  = 1'b0;
        start_i   = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        chk("annul_ready", 64'(ready_o), 64'd0);
        run_div(32'd9, 32'd4, 1'b0, 0, "after_annul");

        // Synchronous reset mid-division clears the outputs.
        @(negedge clk);
        opdata1_i = 32'h0000_FFFF;
        opdata2_i = 32'd3;
        signed_i  = 1'b0;
        start_i   = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(ready_o), 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        chk("rst_mid_stall", 64'(stall_o), 64'd1);
        start_i = 1'b0;
        #1;
        chk("rst_mid_stall_low", 64'(stall_o), 64'd0);
        rst = 1'b0;
        run_div(32'd77, 32'd5, 1'b1, 1, "after_rst");

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            case (kind)
                1: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : (32'd0 - 32'($urandom_range(1, 15)));
                2: b = 32'd0;
                3: a = 32'($urandom_range(0, 255));
                4: begin
                    a = 32'h8000_0000;
                    b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 3));
                end
                default: ;
            endcase
            run_div(a, b, sgn, $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
